// File: rtl/alu_seq_exec_if.sv
// alu_seq_exec_if
// Handshake and data bundle for the multi-cycle execute unit.
//   master : requester side (drives start_i, alu_operation_i, a_i, b_i)
//   slave  : execute unit side (drives ready_o, done_o, result_o, zero_o)
interface alu_seq_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            alu_operation_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  ready_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i,
    input  ready_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i,
    output ready_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_seq_exec.sv
// alu_seq_exec
// Multi-cycle execute unit. ADD/SUB/OR/LUI and unknown codes finish with no
// shift cycles; SRL/SLL shift the result register one bit per cycle.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-low reset
//   bus    : slave side of alu_seq_exec_if
//            start_i/alu_operation_i/a_i/b_i in, ready_o/done_o/result_o/zero_o out
module alu_seq_exec #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  alu_seq_exec_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] result;
  logic [SHAMT_W-1:0]    count;
  logic                  shift_left;
  logic                  ready;
  logic                  done;

  logic                  is_shift;
  logic [SHAMT_W-1:0]    shamt;

  // Single-cycle ops; shifts are handled by the SHIFT state instead.
  function automatic logic [DATA_WIDTH-1:0] alu_comb(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    case (op)
      OP_ADD:  alu_comb = a + b;
      OP_SUB:  alu_comb = a - b;
      OP_OR:   alu_comb = a | b;
      OP_LUI:  alu_comb = b;
      default: alu_comb = '0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_one(
    input logic                  left,
    input logic [DATA_WIDTH-1:0] v
  );
    if (left) shift_one = {v[DATA_WIDTH-2:0], 1'b0};
    else      shift_one = {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  assign is_shift = (bus.alu_operation_i == OP_SRL) || (bus.alu_operation_i == OP_SLL);
  assign shamt    = bus.b_i[SHAMT_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      result     <= '0;
      count      <= '0;
      shift_left <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            ready <= 1'b0;
            if (is_shift) begin
              // Shifts start from operand A and iterate in place.
              result     <= bus.a_i;
              shift_left <= (bus.alu_operation_i == OP_SLL);
              count      <= shamt;
              if (shamt == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= SHIFT;
              end
            end else begin
              result <= alu_comb(bus.alu_operation_i, bus.a_i, bus.b_i);
              state  <= DONE;
              done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result <= shift_one(shift_left, result);
          count  <= count - 1'b1;
          // Last shift lands on the same edge that enters DONE.
          if (count == SHAMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready;
  assign bus.done_o   = done;
  assign bus.result_o = result;
  assign bus.zero_o   = (result == '0);

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle execute unit sitting directly downstream of the ALU control decoder. It consumes the 4-bit ALU operation code plus two operands, computes the result, and reports completion through a start/ready/done handshake. ADD, SUB, OR and LUI-pass complete with zero shift cycles. SRL and SLL use a one-bit-per-cycle serial shifter, so latency depends on the shift amount. It replaces a purely combinational ALU wherever a small-area, iterative shifter is preferred.

## Interface
- DATA_WIDTH, 32, operand/result width; must be ≥ 2
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount field width, taken from B[SHAMT_W-1:0]
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- start_i  input  1  request; accepted only on an edge where ready_o=1
- alu_operation_i  input  4  operation code from the ALU control decoder
- a_i  input  DATA_WIDTH  operand A (rs1 data)
- b_i  input  DATA_WIDTH  operand B (rs2 data or immediate)
- ready_o  output  1  high only in IDLE
- done_o  output  1  single-cycle completion pulse
- result_o  output  DATA_WIDTH  registered result, held until next accept
- zero_o  output  1  (result_o == 0), combinational from the result register

## Operation
- Op codes: 0000 ADD a+b; 0001 SUB a−b; 0011 OR a|b; 0101 LUI result=b; 0110 SRL logical right by b[SHAMT_W-1:0]; 0111 SLL left by b[SHAMT_W-1:0]; any other code gives result 0, with zero shift cycles.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow outputs.
- States: IDLE, SHIFT, DONE.
- IDLE: ready_o=1. On an edge with start_i=1, latch the operation, a_i and b_i.
  - Non-shift op: write result to result_o; go to DONE.
  - Shift op with shamt=0: result_o←a_i; go to DONE.
  - Shift op with shamt=n>0: result_o←a_i; count←n; go to SHIFT.
- SHIFT: each edge shifts result_o by 1 bit (zero fill: left for SLL, right for SRL) and decrements count. The edge on which count==1 shifts and goes to DONE.
- DONE: done_o=1, ready_o=0; next edge goes to IDLE unconditionally.
- Inputs after the accept edge are ignored; operands may change freely during SHIFT.
- start_i while ready_o=0 is ignored and is not queued.
- Intermediate shift values are visible on result_o during SHIFT; consumers use result_o only on done_o or afterwards.

## Timing
- Reset (reset=0 at an edge): state=IDLE, result_o=0, count=0, ready_o=1, done_o=0, zero_o=1. Reset is checked before all other conditions and aborts any SHIFT in progress; that result is lost.
- Let E0 be the accept edge and k the number of shift cycles: k=shamt for SRL/SLL, k=0 otherwise.
  - done_o is high for exactly the cycle between edges E(k+1)−1 and E(k+1), i.e. after edge Ek.
  - ready_o returns high after edge E(k+1).
- Minimum accept-to-accept spacing is k+2 edges.
- result_o and zero_o stay stable from done_o until the next accept edge.
- Maximum latency: DATA_WIDTH−1 shift cycles (shamt=31 at DATA_WIDTH=32).

## Test plan
- ADD wrap: a=0xFFFFFFFF, b=0x00000002, op=0000 → done_o one cycle after the accept edge; result_o=0x00000001, zero_o=0.
- SUB to zero: a=b=0x12345678, op=0001 → result_o=0, zero_o=1. Then OR 0xF0F00000|0x0000F0F0 → 0xF0F0F0F0. Then LUI b=0xABCDE000 → 0xABCDE000.
- SLL shamt=31, a=0x00000001, b=0x0000001F → done_o after edge E31, result_o=0x80000000, ready_o low for 32 edges. SRL shamt=4, a=0x80000000 → 0x08000000 after E4.
- Shift by 0: SRL, b=0x00000020 (shamt=0), a=0xDEADBEEF → done after E0, result_o=0xDEADBEEF. Unknown op 1111 → result_o=0, zero_o=1.
- start_i held high continuously with changing operands during a 5-cycle SLL → only the first request executes, and the next is accepted the edge after DONE. Result matches the originally latched operands.
- reset=0 at edge E3 of a 10-cycle SRL → next cycle IDLE, result_o=0, done_o never pulses, ready_o=1, zero_o=1.
